operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter RUN_CYCLES, default 3: number of clock cycles the downstream datapath is allowed to compute before its result is sampled; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 Clr  input  1  reset, synchronous, active-high.
REQ-004 din  input  8  operand byte stream, ordered A, then B, then C.
REQ-005 din_valid  input  1  din holds a valid byte this cycle.
REQ-006 din_ready  output  1  sequencer accepts a byte this cycle.
REQ-007 mode_in  input  1  operation select, sampled together with byte A.
REQ-008 A, B, C  output  8 each  held operands to the datapath.
REQ-009 E  output  1  held operation select to the datapath.
REQ-010 dp_clr_n  output  1  active-low clear to the datapath register and counter.
REQ-011 busy  output  1  high in CLEAR and RUN.
REQ-012 res_in  input  8  datapath result (T).
REQ-013 res  output  8  captured result.
REQ-014 res_valid  output  1  res holds a captured result.
REQ-015 res_ready  input  1  consumer accepts res this cycle.

Function
REQ-016 The FSM SHALL have four states: COLLECT, CLEAR, RUN and DONE.
REQ-017 A byte SHALL be accepted on a rising edge only when din_valid and din_ready are both high; din_ready SHALL be high only in COLLECT.
REQ-018 A 2-bit index (0..2) SHALL select the destination of each accepted byte (0 -> A, 1 -> B, 2 -> C); the index increments on each accept and returns to 0 after C.
REQ-019 mode_in SHALL be latched into E on the edge that accepts byte A; mode_in SHALL be ignored at all other times.
REQ-020 On the accept of C, the FSM SHALL go COLLECT -> CLEAR; CLEAR lasts exactly 1 cycle, with dp_clr_n=0 during it.
REQ-021 CLEAR SHALL go to RUN unconditionally; dp_clr_n SHALL be 1 in every state except CLEAR.
REQ-022 RUN SHALL last exactly RUN_CYCLES cycles, timed by a 4-bit down-counter loaded on entry to RUN.
REQ-023 On the edge ending the last RUN cycle, res SHALL capture res_in, and the FSM SHALL go to DONE with res_valid=1.
REQ-024 In DONE, res_valid SHALL stay 1 and res SHALL stay stable until res_ready=1.
REQ-025 When res_ready=1 in DONE, the FSM SHALL go to COLLECT on that edge; res_valid SHALL be 0 from the next cycle.
REQ-026 res_ready SHALL be ignored outside DONE.
REQ-027 din_ready SHALL be 0 in CLEAR, RUN and DONE, so no byte is lost or overwritten there; din_valid in those states has no effect.
REQ-028 A, B, C and E SHALL hold constant from the accept of C until the FSM leaves DONE.
REQ-029 In COLLECT, A, B and C SHALL update only as their bytes are accepted.
REQ-030 res SHALL retain its last value after DONE exits, until the next capture.
REQ-031 din_valid low in the middle of a collection SHALL stall the sequence, with the index kept; there is no timeout.
REQ-032 All registered outputs SHALL come directly from flops; din_ready, busy and dp_clr_n SHALL be decoded from state only.

Reset
REQ-033 With Clr=1 at a rising edge, the block SHALL set: state=COLLECT, index=0, A=B=C=0, E=0, res=0, res_valid=0, RUN counter=0.
REQ-034 Reset SHALL take priority over every other event, including a byte accept or res_ready in the same cycle.
REQ-035 Reset mid-operation (in CLEAR, RUN or DONE) SHALL abort without capturing res_in.
REQ-036 During reset cycles, dp_clr_n SHALL be 1, din_ready SHALL be 1 and busy SHALL be 0.

Verification
REQ-037 Basic run: Clr 1->0; stream 8'h02 (mode_in=0), 8'h04, 8'h03 back-to-back -> A=2, B=4, C=3, E=0; dp_clr_n low exactly 1 cycle after the C accept; res_valid rises 1+RUN_CYCLES cycles after the C accept with res = res_in (bench drives 8'h06).
REQ-038 Stall: din_valid toggled 1,0,0,1,0,1 -> exactly three accepts, in order A, B, C; index never skips.
REQ-039 Backpressure: res_ready held 0 for 5 cycles in DONE, with din_valid=1 -> res_valid and res stable throughout; din_ready=0; no operand changes.
REQ-040 Back-to-back jobs: res_ready=1 on the first DONE cycle, next stream 8'h02 (mode_in=1), 8'h04, 8'h03 -> E=1; din_ready=1 in the cycle after the handshake; second result captured correctly.
REQ-041 Reset mid-RUN: Clr=1 on the second RUN cycle -> next cycle all outputs at reset values; res_valid never asserts; a following job completes normally.
REQ-042 RUN_CYCLES=1 build: res captured on the edge immediately after CLEAR; total C-accept-to-res_valid latency is 2 cycles.

Source files
------------

// File: rtl/operand_sequencer.sv
// operand_sequencer: collects the A/B/C operand bytes plus an operation select,
// clears the downstream datapath for one cycle, lets it compute for
// RUN_CYCLES cycles, then captures and holds its result until it is consumed.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_COLLECT | accepting operand bytes A, B, C (din_ready high)
// S_CLEAR   | one cycle with dp_clr_n low to clear the datapath
// S_RUN     | datapath computing, RUN down-counter timing the window
// S_DONE    | res_valid high, waiting for res_ready
module operand_sequencer #(
  // legal range 1..15; the RUN window is timed by a 4-bit down-counter
  parameter int RUN_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       Clr,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       mode_in,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [7:0] C,
  output logic       E,
  output logic       dp_clr_n,
  output logic       busy,
  input  logic [7:0] res_in,
  output logic [7:0] res,
  output logic       res_valid,
  input  logic       res_ready
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CLEAR   = 2'd1,
    S_RUN     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Counter holds the number of RUN cycles still to go after the current one.
  localparam logic [3:0] RUN_LOAD = 4'(RUN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] a_q, b_q, c_q;
  logic       e_q;
  logic [7:0] res_q;
  logic       res_valid_q;

  logic accept;
  logic run_last;

  assign accept   = din_valid & din_ready;
  assign run_last = (state_q == S_RUN) && (cnt_q == 4'd0);

  // State, operand index and RUN counter registers.
  always_ff @(posedge CLK) begin
    if (Clr) begin
      state_q <= S_COLLECT;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (accept && (idx_q == 2'd2)) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_RUN;
      S_RUN:     if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:    if (res_ready) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Operand index wraps A -> B -> C -> A; RUN counter loads while in CLEAR.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (accept) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    if (state_q == S_CLEAR) begin
      cnt_d = RUN_LOAD;
    end else if ((state_q == S_RUN) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Handshake and datapath controls decoded from state alone.
  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b0;
    dp_clr_n  = 1'b1;
    case (state_q)
      S_COLLECT: din_ready = 1'b1;
      S_CLEAR: begin
        busy     = 1'b1;
        dp_clr_n = 1'b0;
      end
      S_RUN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept; result capture at the end of RUN, held until consumed.
  always_ff @(posedge CLK) begin
    if (Clr) begin
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      c_q         <= 8'd0;
      e_q         <= 1'b0;
      res_q       <= 8'd0;
      res_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        case (idx_q)
          2'd0: begin
            a_q <= din;
            e_q <= mode_in;
          end
          2'd1:    b_q <= din;
          default: c_q <= din;
        endcase
      end
      if (run_last) begin
        res_q       <= res_in;
        res_valid_q <= 1'b1;
      end else if ((state_q == S_DONE) && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign E         = e_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Testbench for operand_sequencer: random and directed jobs against a
// cycle-level reference model with a result scoreboard, plus a small
// directed run on a RUN_CYCLES=1 instance.
module tb_operand_sequencer;

  localparam int R = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Clr, din_valid, mode_in, res_ready;
  logic [7:0] din, res_in;
  logic       din_ready, E, dp_clr_n, busy, res_valid;
  logic [7:0] A, B, C, res;

  operand_sequencer #(.RUN_CYCLES(R)) u_dut (
    .CLK(CLK), .Clr(Clr), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .mode_in(mode_in), .A(A), .B(B), .C(C), .E(E), .dp_clr_n(dp_clr_n), .busy(busy),
    .res_in(res_in), .res(res), .res_valid(res_valid), .res_ready(res_ready)
  );

  logic       Clr1, dv1, mode1, rr1;
  logic [7:0] din1, rin1;
  logic       dr1, E1, dpc1, busy1, rv1;
  logic [7:0] A1, B1, C1, res1;
  bit         d1_done = 1'b0;

  operand_sequencer #(.RUN_CYCLES(1)) u_dut1 (
    .CLK(CLK), .Clr(Clr1), .din(din1), .din_valid(dv1), .din_ready(dr1),
    .mode_in(mode1), .A(A1), .B(B1), .C(C1), .E(E1), .dp_clr_n(dpc1), .busy(busy1),
    .res_in(rin1), .res(res1), .res_valid(rv1), .res_ready(rr1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail(string name, int a, int e);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d at t=%0t", name, a, e, $time);
  endfunction

  // Cycle index and the datapath result stream: a distinct value every cycle
  int         cyc = 0;
  bit         use_fixed = 1'b0;
  logic [7:0] fixed_res = 8'h00;

  function automatic logic [7:0] res_at(int m);
    if (use_fixed) return fixed_res;
    return 8'((m * 29) ^ 8'h5A);
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) begin
    #1;
    res_in = res_at(cyc);
  end

  // Reference model
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       e;
    logic [7:0] r;
    int         vcyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_c = 8'h00;
  logic       m_e = 1'b0;
  int         m_idx = 0;
  int         clr_cyc = -1000;
  bit         armed = 1'b0;

  // One clock cycle: sample the handshake mid-cycle, advance the model after the edge
  task automatic tick(input bit collecting);
    bit   acc, rst;
    int   n;
    exp_t it;
    @(negedge CLK);
    acc = din_valid && din_ready;
    rst = Clr;
    n   = cyc;
    @(posedge CLK);
    #1;
    if (rst) begin
      m_a = 8'h00; m_b = 8'h00; m_c = 8'h00; m_e = 1'b0;
      m_idx = 0; clr_cyc = -1000;
      sb.delete();
      armed = 1'b1;
    end else if (collecting && acc) begin
      case (m_idx)
        0: begin m_a = din; m_e = mode_in; end
        1: m_b = din;
        default: begin
          m_c = din;
          clr_cyc = n + 1;
          it.a = m_a; it.b = m_b; it.c = din; it.e = m_e;
          it.r = res_at(n + 1 + R);
          it.vcyc = n + 2 + R;
          sb.push_back(it);
        end
      endcase
      m_idx = (m_idx + 1) % 3;
    end
  endtask

  // Monitor: pops the scoreboard when the DUT presents a result, checks every cycle
  bit         hold = 1'b0, hs_prev = 1'b0, prev_clr = 1'b0;
  logic [7:0] last_res = 8'h00;

  always @(negedge CLK) begin
    exp_t it;
    bit   exp_busy;
    if (armed) begin
      if (prev_clr) begin
        hold = 1'b0; hs_prev = 1'b0; last_res = 8'h00;
      end else if (hs_prev) begin
        hold = 1'b0;
      end
      if (res_valid && !hold && sb.size() > 0) begin
        it = sb.pop_front();
        chk("res_cycle", cyc, it.vcyc);
        chk("res_value", res, it.r);
        chk("res_A", A, it.a);
        chk("res_B", B, it.b);
        chk("res_C", C, it.c);
        chk("res_E", E, it.e);
        hold = 1'b1;
        last_res = it.r;
      end
      if (sb.size() > 0 && cyc > sb[0].vcyc) begin
        fail("res_missing_cycle", cyc, sb[0].vcyc);
        void'(sb.pop_front());
      end
      exp_busy = (cyc >= clr_cyc) && (cyc <= clr_cyc + R);
      chk("busy", busy, exp_busy);
      chk("dp_clr_n", dp_clr_n, cyc != clr_cyc);
      chk("din_ready", din_ready, !(exp_busy || hold));
      chk("res_valid", res_valid, hold);
      chk("res_stable", res, last_res);
      chk("A", A, m_a);
      chk("B", B, m_b);
      chk("C", C, m_c);
      chk("E", E, m_e);
      hs_prev = hold && res_ready;
    end
    prev_clr = Clr;
  end

  // One job: collect three bytes, ride out CLEAR/RUN, backpressure, handshake
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic mode, input int stall_pct, input logic [5:0] pat,
                         input bit use_pat, input int bp, input int abort_off);
    logic [7:0] bytes [3];
    int k, g, vc;
    bit v;
    bytes[0] = a; bytes[1] = b; bytes[2] = c;
    k = 0; g = 0;
    while (k < 3 && g < 200) begin
      v = use_pat ? pat[g % 6] : ($urandom_range(99) >= stall_pct);
      din_valid = v;
      din       = v ? bytes[k] : 8'($urandom);
      mode_in   = (k == 0 && v) ? mode : 1'($urandom);
      res_ready = 1'($urandom);
      tick(1'b1);
      if (m_idx != k) k++;
      g++;
    end
    if (k < 3) begin
      fail("collect_timeout_accepts", k, 3);
      return;
    end
    if (use_pat) chk("stall_cycles_for_3_accepts", g, 6);
    vc = clr_cyc + 1 + R;
    while (cyc < vc) begin
      din_valid = 1'($urandom);
      din       = 8'($urandom);
      mode_in   = 1'($urandom);
      res_ready = 1'($urandom);
      if (abort_off >= 0 && cyc == clr_cyc + abort_off) begin
        Clr = 1'b1;
        tick(1'b0);
        Clr = 1'b0;
        din_valid = 1'b0;
        res_ready = 1'b0;
        return;
      end
      tick(1'b0);
    end
    for (int i = 0; i < bp; i++) begin
      din_valid = 1'b1;
      din       = 8'($urandom);
      mode_in   = 1'($urandom);
      res_ready = 1'b0;
      tick(1'b0);
    end
    res_ready = 1'b1;
    din_valid = 1'($urandom);
    tick(1'b0);
    res_ready = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    Clr = 1'b1; din_valid = 1'b0; din = 8'h00; mode_in = 1'b0; res_ready = 1'b0;
    tick(1'b0);
    tick(1'b0);
    Clr = 1'b0;

    use_fixed = 1'b1;
    fixed_res = 8'h06;
    run_job(8'h02, 8'h04, 8'h03, 1'b0, 0, 6'd0, 1'b0, 0, -1);
    use_fixed = 1'b0;

    run_job(8'h10, 8'h20, 8'h30, 1'b1, 0, 6'b101001, 1'b1, 5, -1);
    run_job(8'h02, 8'h04, 8'h03, 1'b1, 0, 6'd0, 1'b0, 0, -1);

    run_job(8'hAA, 8'h55, 8'h0F, 1'b1, 0, 6'd0, 1'b0, 0, 2);
    repeat (3) tick(1'b1);
    run_job(8'h81, 8'h42, 8'h24, 1'b0, 0, 6'd0, 1'b0, 1, -1);

    din_valid = 1'b1; din = 8'h11; mode_in = 1'b1; tick(1'b1);
    Clr = 1'b1; din = 8'h22; res_ready = 1'b1; tick(1'b1);
    Clr = 1'b0; din_valid = 1'b0; res_ready = 1'b0; tick(1'b1);

    for (int j = 0; j < 25; j++) begin
      run_job(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 40,
              6'd0, 1'b0, $urandom_range(0, 4), -1);
    end
    tick(1'b1);
    tick(1'b1);

    for (int i = 0; i < 100 && !d1_done; i++) @(posedge CLK);
    chk("run1_instance_done", d1_done, 1'b1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // RUN_CYCLES=1 instance: capture on the edge right after CLEAR
  initial begin
    Clr1 = 1'b1; dv1 = 1'b0; din1 = 8'h00; mode1 = 1'b0; rr1 = 1'b0; rin1 = 8'h5C;
    @(posedge CLK); #1;
    Clr1 = 1'b0;
    @(negedge CLK);
    chk("r1_reset_din_ready", dr1, 1'b1);
    chk("r1_reset_dp_clr_n", dpc1, 1'b1);
    chk("r1_reset_busy", busy1, 1'b0);
    @(posedge CLK); #1;
    dv1 = 1'b1; mode1 = 1'b1; din1 = 8'h21;
    @(posedge CLK); #1;
    mode1 = 1'b0; din1 = 8'h22;
    @(posedge CLK); #1;
    din1 = 8'h23;
    @(posedge CLK); #1;
    dv1 = 1'b0;
    @(negedge CLK);
    chk("r1_clear_dp_clr_n", dpc1, 1'b0);
    chk("r1_clear_busy", busy1, 1'b1);
    chk("r1_clear_res_valid", rv1, 1'b0);
    @(posedge CLK); #1;
    rin1 = 8'h77;
    @(negedge CLK);
    chk("r1_run_dp_clr_n", dpc1, 1'b1);
    chk("r1_run_busy", busy1, 1'b1);
    chk("r1_run_res_valid", rv1, 1'b0);
    @(posedge CLK); #1;
    rin1 = 8'h99;
    @(negedge CLK);
    chk("r1_done_res_valid", rv1, 1'b1);
    chk("r1_done_res", res1, 8'h77);
    chk("r1_done_busy", busy1, 1'b0);
    chk("r1_done_din_ready", dr1, 1'b0);
    chk("r1_A", A1, 8'h21);
    chk("r1_B", B1, 8'h22);
    chk("r1_C", C1, 8'h23);
    chk("r1_E", E1, 1'b1);
    @(posedge CLK); #1;
    rr1 = 1'b1;
    @(negedge CLK);
    chk("r1_hold_res_valid", rv1, 1'b1);
    chk("r1_hold_res", res1, 8'h77);
    @(posedge CLK); #1;
    rr1 = 1'b0;
    @(negedge CLK);
    chk("r1_after_res_valid", rv1, 1'b0);
    chk("r1_after_din_ready", dr1, 1'b1);
    chk("r1_after_res_kept", res1, 8'h77);
    d1_done = 1'b1;
  end

endmodule
